// File: rtl/stack_param.sv
// rtl/stack_param.sv - parametrised LIFO stack with registered read, flags and error strobe
module stack_param #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 5,
    parameter int OVERWRITE = 0,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       COMMAND,
    input  logic [IW-1:0]    INDEX,
    input  logic [WIDTH-1:0] I_DATA,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    output logic [CW-1:0]    COUNT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ERROR
);

    // Sum width: bottom pointer plus occupancy stays below 2*DEPTH.
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]    bp_q, bp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             o_valid_q, o_valid_d;
    logic             error_q, error_d;

    logic             wr_en;
    logic [IW-1:0]    wr_addr;
    logic [IW-1:0]    push_slot;
    logic [IW-1:0]    bp_next;
    logic [IW-1:0]    rd_idx;
    logic             rd_ok;
    logic [IW-1:0]    rd_slot;
    logic             full, empty;
    cmd_e             cmd;

    function automatic logic [IW-1:0] wrap(input logic [SW-1:0] x);
        if (x >= SW'(DEPTH)) begin
            wrap = IW'(x - SW'(DEPTH));
        end else begin
            wrap = IW'(x);
        end
    endfunction

    assign cmd       = cmd_e'(COMMAND);
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_slot = wrap(SW'(bp_q) + SW'(count_q));
    assign bp_next   = wrap(SW'(bp_q) + SW'(1));

    // POP and GET share one read port: POP is a GET of offset zero.
    assign rd_idx  = (cmd == CMD_POP) ? '0 : INDEX;
    assign rd_ok   = (SW'(rd_idx) < SW'(count_q));
    assign rd_slot = rd_ok ? wrap(SW'(bp_q) + SW'(count_q) - SW'(1) - SW'(rd_idx)) : '0;

    always_comb begin
        bp_d      = bp_q;
        count_d   = count_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        error_d   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = push_slot;
        case (cmd)
            CMD_PUSH: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end else if (OVERWRITE != 0) begin
                    // Full in history mode: oldest entry is replaced and the bottom advances.
                    wr_en   = 1'b1;
                    wr_addr = bp_q;
                    bp_d    = bp_next;
                end else begin
                    error_d = 1'b1;
                end
            end
            CMD_POP: begin
                if (rd_ok) begin
                    o_data_d  = mem_q[rd_slot];
                    o_valid_d = 1'b1;
                    count_d   = count_q - CW'(1);
                end else begin
                    error_d = 1'b1;
                end
            end
            CMD_GET: begin
                if (rd_ok) begin
                    o_data_d  = mem_q[rd_slot];
                    o_valid_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bp_q      <= '0;
            count_q   <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            bp_q      <= bp_d;
            count_q   <= count_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            error_q   <= error_d;
        end
    end

    // Array contents survive reset; they are unreachable until pushed again.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= I_DATA;
        end
    end

    assign O_DATA  = o_data_q;
    assign O_VALID = o_valid_q;
    assign COUNT   = count_q;
    assign EMPTY   = empty;
    assign FULL    = full;
    assign ERROR   = error_q;

endmodule

// File: tb/tb_stack_param.sv
// tb/tb_stack_param.sv - randomized bench for stack_param against an array-based LIFO model
module tb_stack_param;

    localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, GET = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cmd = NOP;
    logic [7:0] din = '0;
    logic [2:0] idx = '0;

    always #5 clk = ~clk;

    // Instance 0: 4x5 reject; instance 1: 4x5 overwrite; instance 2: 8x3 reject.
    logic [3:0] o_data0, o_data1;
    logic [7:0] o_data2;
    logic [2:0] count0, count1;
    logic [1:0] count2;
    logic       v0, v1, v2, e0, e1, e2, em0, em1, em2, f0, f1, f2;

    stack_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(0)) u_s0 (
        .CLK(clk), .RESET(rst), .COMMAND(cmd), .INDEX(idx), .I_DATA(din[3:0]),
        .O_DATA(o_data0), .O_VALID(v0), .COUNT(count0), .EMPTY(em0), .FULL(f0), .ERROR(e0));
    stack_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(1)) u_s1 (
        .CLK(clk), .RESET(rst), .COMMAND(cmd), .INDEX(idx), .I_DATA(din[3:0]),
        .O_DATA(o_data1), .O_VALID(v1), .COUNT(count1), .EMPTY(em1), .FULL(f1), .ERROR(e1));
    stack_param #(.WIDTH(8), .DEPTH(3), .OVERWRITE(0)) u_s2 (
        .CLK(clk), .RESET(rst), .COMMAND(cmd), .INDEX(idx[1:0]), .I_DATA(din),
        .O_DATA(o_data2), .O_VALID(v2), .COUNT(count2), .EMPTY(em2), .FULL(f2), .ERROR(e2));

    logic [7:0] d_data [3];
    logic [2:0] d_count [3];
    logic       d_valid [3], d_err [3], d_empty [3], d_full [3];

    assign d_data[0] = {4'd0, o_data0};
    assign d_data[1] = {4'd0, o_data1};
    assign d_data[2] = o_data2;
    assign d_count[0] = count0;
    assign d_count[1] = count1;
    assign d_count[2] = {1'b0, count2};
    assign d_valid[0] = v0;  assign d_valid[1] = v1;  assign d_valid[2] = v2;
    assign d_err[0]   = e0;  assign d_err[1]   = e1;  assign d_err[2]   = e2;
    assign d_empty[0] = em0; assign d_empty[1] = em1; assign d_empty[2] = em2;
    assign d_full[0]  = f0;  assign d_full[1]  = f1;  assign d_full[2]  = f2;

    int P_W  [3] = '{4, 4, 8};
    int P_D  [3] = '{5, 5, 3};
    int P_OW [3] = '{0, 1, 0};
    int P_IW [3] = '{3, 3, 2};

    // Model: stk[k][0] is the bottom, stk[k][cnt-1] the top.
    logic [7:0] m_stk [3][8];
    int         m_cnt [3];
    logic [7:0] m_data [3];
    logic       m_valid [3], m_err [3];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_data[k] = '0; m_valid[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    task automatic model_apply(input logic [1:0] c, input logic [7:0] dt, input logic [2:0] ix);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] d;
            int         i;
            d = (P_W[k] == 8) ? dt : {4'd0, dt[3:0]};
            i = int'(ix) & ((1 << P_IW[k]) - 1);
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            case (c)
                PUSH: begin
                    if (m_cnt[k] < P_D[k]) begin
                        m_stk[k][m_cnt[k]] = d;
                        m_cnt[k]++;
                    end else if (P_OW[k] != 0) begin
                        for (int j = 0; j < P_D[k] - 1; j++) m_stk[k][j] = m_stk[k][j+1];
                        m_stk[k][P_D[k]-1] = d;
                    end else begin
                        m_err[k] = 1'b1;
                    end
                end
                POP: begin
                    if (m_cnt[k] > 0) begin
                        m_cnt[k]--;
                        m_data[k]  = m_stk[k][m_cnt[k]];
                        m_valid[k] = 1'b1;
                    end else begin
                        m_err[k] = 1'b1;
                    end
                end
                GET: begin
                    if (i < m_cnt[k]) begin
                        m_data[k]  = m_stk[k][m_cnt[k]-1-i];
                        m_valid[k] = 1'b1;
                    end else begin
                        m_err[k] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("i%0d o_data", k),  32'(d_data[k]),  32'(m_data[k]));
            chk($sformatf("i%0d o_valid", k), 32'(d_valid[k]), 32'(m_valid[k]));
            chk($sformatf("i%0d error", k),   32'(d_err[k]),   32'(m_err[k]));
            chk($sformatf("i%0d count", k),   32'(d_count[k]), 32'(m_cnt[k]));
            chk($sformatf("i%0d empty", k),   32'(d_empty[k]), 32'(m_cnt[k] == 0));
            chk($sformatf("i%0d full", k),    32'(d_full[k]),  32'(m_cnt[k] == P_D[k]));
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [7:0] dt, input logic [2:0] ix);
        cmd = c; din = dt; idx = ix;
        @(posedge clk);
        model_apply(c, dt, ix);
        #1;
        check_all();
    endtask

    // Called right after step(): reset pulse lies wholly between two edges.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #2 rst = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        for (int n = 1; n <= 3; n++) step(PUSH, 8'(n), 0);
        chk("plan count3", 32'(count0), 32'd3);
        for (int n = 0; n <= 4; n++) begin
            step(GET, 0, 3'(n));
            if (n == 0) chk("plan get0", 32'(o_data0), 32'd3);
            if (n == 3) chk("plan get3 error", 32'(e0), 32'd1);
        end
        chk("plan hold1", 32'(o_data0), 32'd1);
        for (int n = 0; n < 4; n++) step(POP, 0, 0);
        chk("plan pop empty", 32'(em0), 32'd1);

        for (int n = 1; n <= 6; n++) step(PUSH, 8'(n), 0);
        chk("plan reject full", 32'(e0), 32'd1);
        step(GET, 0, 0);
        chk("plan get0 full", 32'(o_data0), 32'd5);

        rst = 1'b1; #1; model_reset(); rst = 1'b0;
        for (int n = 1; n <= 7; n++) step(PUSH, 8'(n), 0);
        for (int n = 0; n <= 4; n++) step(GET, 0, 3'(n));
        chk("plan ow get4", 32'(o_data1), 32'd3);
        for (int n = 0; n < 5; n++) step(POP, 0, 0);
        chk("plan ow last pop", 32'(o_data1), 32'd3);

        for (int n = 1; n <= 3; n++) step(PUSH, 8'(8'hA0 + n), 0);
        step(GET, 0, 1);
        async_reset();
        step(POP, 0, 0);
        chk("plan pop after reset", 32'(e0), 32'd1);

        for (int it = 0; it < 1500; it++) begin
            int r;
            logic [1:0] c;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                async_reset();
            end else begin
                if (r < 42)      c = PUSH;
                else if (r < 67) c = POP;
                else if (r < 92) c = GET;
                else             c = NOP;
                step(c, 8'($urandom), 3'($urandom_range(0, 7)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
